// File: rtl/pb_seq_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : pb_seq_pkg                                              |
// | Description : Shared types and constants for the pushbutton sequencer |
// |               (state encoding, key/pb widths, key-to-pb decode).      |
// | Revision    : 1.0 - initial release                                   |
// +-----------------------------------------------------------------------+
package pb_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2
  } state_e;

  localparam int c_KEY_W = 4;
  localparam int c_PB_W  = 10;

  // Codes at or above this value have no pushbutton and are rejected.
  localparam logic [c_KEY_W-1:0] c_INVALID_CODE = 4'd10;

  // One-hot pushbutton pattern for a key code; zero for invalid codes so
  // the pb bus can never carry more than one set bit.
  function automatic logic [c_PB_W-1:0] code_to_pb(input logic [c_KEY_W-1:0] code);
    logic [c_PB_W-1:0] one;
    one = c_PB_W'(1);
    if (code < c_INVALID_CODE) begin
      return one << code;
    end
    return '0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pb_seq_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : pb_seq_fifo                                             |
// | Description : Synchronous key-code queue with show-ahead read port,   |
// |               occupancy counter and full/empty flags.                 |
// | Revision    : 1.0 - initial release                                   |
// +-----------------------------------------------------------------------+
module pb_seq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_CNT_W-1:0] count_q, count_d;
  logic               do_push, do_pop;

  assign full     = (count_q == c_CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  // Pointer and occupancy update; power-of-two depth makes pointers wrap naturally.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = do_push ? wr_ptr_q + c_PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + c_PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + c_CNT_W'(1);
      2'b01:   count_d = count_q - c_CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state registers; reset empties the queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pb_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : pb_sequencer                                            |
// | Description : Queues key codes and replays each as a timed press on   |
// |               a one-hot pushbutton bus, separated by idle gaps.       |
// | Revision    : 1.0 - initial release                                   |
// +-----------------------------------------------------------------------+
module pb_sequencer
  import pb_seq_pkg::*;
#(
  parameter int PRESS_CYCLES = 1000,
  parameter int GAP_CYCLES   = 1000,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key_valid,
  input  logic [c_KEY_W-1:0] key_code,
  output logic               key_ready,
  output logic [c_PB_W-1:0]  pb,
  output logic               busy,
  output logic               err
);

  localparam int c_CNT_MAX = (PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES;
  localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
  localparam int c_OCC_W   = $clog2(FIFO_DEPTH) + 1;

  // Counter counts down to zero, so a phase of N cycles reloads with N-1.
  localparam logic [c_CNT_W-1:0] c_PRESS_RELOAD = c_CNT_W'(PRESS_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_GAP_RELOAD   = c_CNT_W'(GAP_CYCLES - 1);

  state_e               state_q, state_d;
  logic [c_CNT_W-1:0]   cnt_q, cnt_d;
  logic [c_PB_W-1:0]    pb_q, pb_d;
  logic                 err_q, err_d;

  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [c_KEY_W-1:0]   fifo_head;
  logic [c_OCC_W-1:0]   fifo_count;
  logic                 accept, code_ok;

  pb_seq_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (c_KEY_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (key_code),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign key_ready = !fifo_full;
  assign pb        = pb_q;
  assign err       = err_q;
  assign busy      = (state_q != IDLE) || (fifo_count != '0);

  // Handshake: valid codes go to the queue, invalid ones only raise err.
  always_comb begin
    accept    = key_valid && key_ready;
    code_ok   = (key_code < c_INVALID_CODE);
    fifo_push = accept && code_ok;
    err_d     = accept && !code_ok;
  end

  // Next-state logic: press/gap timing and head-of-queue pop on press start.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pb_d     = pb_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        pb_d = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = PRESS;
          cnt_d    = c_PRESS_RELOAD;
          pb_d     = code_to_pb(fifo_head);
        end
      end
      PRESS: begin
        if (cnt_q == '0) begin
          state_d = GAP;
          cnt_d   = c_GAP_RELOAD;
          pb_d    = '0;
        end else begin
          cnt_d = cnt_q - c_CNT_W'(1);
        end
      end
      GAP: begin
        pb_d = '0;
        if (cnt_q == '0) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            state_d  = PRESS;
            cnt_d    = c_PRESS_RELOAD;
            pb_d     = code_to_pb(fifo_head);
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - c_CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        pb_d    = '0;
      end
    endcase
  end

  // State, counter and registered outputs; reset drops pb immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pb_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pb_q    <= pb_d;
      err_q   <= err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pb_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : tb_pb_sequencer                                         |
// | Description : Scoreboard bench for pb_sequencer (P=4, G=2, depth 4).  |
// | Revision    : 1.0 - initial release                                   |
// +-----------------------------------------------------------------------+
module tb_pb_sequencer;

  localparam int P = 4;
  localparam int G = 2;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic       key_ready, busy, err;
  logic [9:0] pb;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];
  int err_pending = 0;

  always #5 clk = ~clk;

  pb_sequencer #(
    .PRESS_CYCLES (P),
    .GAP_CYCLES   (G),
    .FIFO_DEPTH   (D)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_ready (key_ready),
    .pb        (pb),
    .busy      (busy),
    .err       (err)
  );

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Offer one code, wait (bounded) for ready, complete the handshake.
  task automatic send(input int code);
    int guard;
    guard     = 0;
    key_valid = 1'b1;
    key_code  = code[3:0];
    while (!key_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 200) begin
      check("ready_timeout", 0, 1);
      key_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (code < 10) exp_q.push_back(code);
    else           err_pending++;
    #1;
    key_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while ((busy || exp_q.size() != 0) && g < 500) begin
      @(posedge clk); #1;
      g++;
    end
    check("idle_timeout", int'(g < 500), 1);
  endtask

  // Monitor: pops expected codes at each press start, checks timing and err.
  initial begin : monitor
    logic [9:0] prev_pb;
    logic       prev_err;
    int         press_len, zero_len, code;
    bit         gap_chk;
    prev_pb = '0; prev_err = 1'b0; press_len = 0; zero_len = 0; gap_chk = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_pb = '0; prev_err = 1'b0; press_len = 0; zero_len = 0; gap_chk = 1'b0;
      end else begin
        check("pb_onehot", int'($countones(pb) <= 1), 1);
        if (err) begin
          check("err_expected", int'(err_pending > 0), 1);
          if (err_pending > 0) err_pending--;
          check("err_one_cycle", int'(prev_err), 0);
        end
        if (pb != '0) begin
          if (prev_pb == '0) begin
            if (gap_chk) check("gap_len", zero_len, G);
            if (exp_q.size() == 0) begin
              check("unexpected_press", int'(pb), 0);
            end else begin
              code = exp_q.pop_front();
              check("press_code", int'(pb), 1 << code);
            end
            press_len = 1;
          end else if (pb != prev_pb) begin
            check("pb_change_in_press", int'(pb), int'(prev_pb));
          end else begin
            press_len++;
          end
        end else begin
          if (prev_pb != '0) begin
            check("press_len", press_len, P);
            gap_chk  = (exp_q.size() > 0);
            zero_len = 0;
          end
          zero_len++;
        end
        prev_pb  = pb;
        prev_err = err;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  // Directed stimulus.
  initial begin : stim
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_pb", int'(pb), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_err", int'(err), 0);
    check("rst_ready", int'(key_ready), 1);

    // Single key 3: pb=bit3 for edges N+1..N+4, zero N+5..N+6, busy low at N+7.
    send(3);
    check("single_pb_N", int'(pb), 0);
    check("single_busy_N", int'(busy), 1);
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
      check("single_pb", int'(pb), (k <= 4) ? 8 : 0);
      check("single_busy", int'(busy), int'(k < 7));
    end

    // Back-to-back 1,2,7: monitor checks order and exact gap lengths.
    send(1);
    send(2);
    send(7);
    wait_idle();

    // Invalid code while idle.
    send(12);
    check("inv_err", int'(err), 1);
    check("inv_pb", int'(pb), 0);
    check("inv_busy", int'(busy), 0);
    @(posedge clk); #1;
    check("inv_err_drop", int'(err), 0);
    check("inv_busy2", int'(busy), 0);
    check("inv_ready", int'(key_ready), 1);

    // Full queue: codes 0-9 offered continuously.
    for (int i = 0; i <= 9; i++) begin
      send(i);
      if (i == 4) check("full_ready", int'(key_ready), 0);
    end
    wait_idle();

    // Simultaneous push and pop at the edge the gap ends.
    send(3);
    send(4);
    repeat (5) @(posedge clk);
    #1;
    send(9);
    check("simul_pb", int'(pb), 16);
    check("simul_ready", int'(key_ready), 1);
    check("simul_busy", int'(busy), 1);
    wait_idle();

    // Reset in the second press cycle with two codes queued; a handshake
    // offered on the reset edge must be dropped too.
    send(5);
    send(6);
    send(8);
    check("rst_mid_pb", int'(pb), 32);
    rst       = 1'b1;
    key_valid = 1'b1;
    key_code  = 4'd2;
    exp_q.delete();
    @(posedge clk); #1;
    rst       = 1'b0;
    key_valid = 1'b0;
    check("rst_mid_pb0", int'(pb), 0);
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_ready", int'(key_ready), 1);
    check("rst_mid_err", int'(err), 0);
    repeat (20) @(posedge clk);
    #1;
    check("rst_after_pb", int'(pb), 0);
    check("rst_after_busy", int'(busy), 0);

    check("exp_q_drained", exp_q.size(), 0);
    check("err_drained", err_pending, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
